// File: rtl/sim_status_pkg.sv
// Shared types for the end-of-test status monitor.
package sim_status_pkg;

    typedef enum logic [1:0] {StRun, StDrain, StDone} sim_status_state_e;

    typedef enum {SigNone, SigPass, SigFail} sig_class_e;

    localparam logic [15:0] TimeoutFailCode = 16'hFFFF;

endpackage

// File: rtl/sim_status_debounce.sv
// Registers the masked GPIO pins, classifies them and requires a signature
// to hold for StableCycles consecutive cycles before it is accepted.
module sim_status_debounce
    import sim_status_pkg::*;
#(
    parameter logic [31:0] PassSig      = 32'hDEADBEEF,
    parameter logic [15:0] FailPrefix   = 16'hBAD0,
    parameter int unsigned StableCycles = 2
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic [31:0] gpio_i,
    input  logic [31:0] gpio_en_i,
    output logic [15:0] fail_code,
    output logic        accept_pass,
    output logic        accept_fail,
    output logic        pins_changed
);

    localparam logic [3:0] StableLast = 4'(StableCycles);

    logic [31:0] pins_q;
    logic [31:0] prev_pins_q;
    logic [3:0]  stable_q;
    logic [3:0]  stable_d;
    logic        reached;
    sig_class_e  sig_class;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pins_q      <= '0;
            prev_pins_q <= '0;
            stable_q    <= '0;
        end else begin
            pins_q      <= gpio_i & gpio_en_i;
            prev_pins_q <= pins_q;
            stable_q    <= stable_d;
        end
    end

    assign pins_changed = (pins_q != prev_pins_q);
    assign fail_code    = pins_q[15:0];

    always_comb begin
        sig_class = SigNone;
        if (pins_q == PassSig) begin
            sig_class = SigPass;
        end else if (pins_q[31:16] == FailPrefix) begin
            sig_class = SigFail;
        end
    end

    // The first cycle a new signature is seen already counts as 1.
    always_comb begin
        stable_d = stable_q;
        if (sig_class == SigNone) begin
            stable_d = '0;
        end else if (pins_changed) begin
            stable_d = 4'd1;
        end else if (stable_q < StableLast) begin
            stable_d = stable_q + 4'd1;
        end
    end

    // Fire once, on the cycle the count arrives, not while it sits saturated.
    assign reached     = (stable_d == StableLast) && (pins_changed || (stable_q != StableLast));
    assign accept_pass = reached && (sig_class == SigPass);
    assign accept_fail = reached && (sig_class == SigFail);

endmodule

// File: rtl/sim_status_monitor.sv
// End-of-test monitor: latches a first-wins verdict from GPIO signatures or a
// progress watchdog, then drains for DrainCycles before requesting finish.
//   state   | meaning
//   StRun   | watching GPIO for a signature or a timeout
//   StDrain | verdict latched, counting down to finish
//   StDone  | finish requested, everything frozen
module sim_status_monitor
    import sim_status_pkg::*;
#(
    parameter logic [31:0] PassSig       = 32'hDEADBEEF,
    parameter logic [15:0] FailPrefix    = 16'hBAD0,
    parameter int unsigned StableCycles  = 2,
    parameter int unsigned DrainCycles   = 7,
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned TimeoutW      = 32
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic [31:0] gpio_i,
    input  logic [31:0] gpio_en_i,
    output logic        finish_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic [15:0] fail_code_o,
    output logic        verdict_pulse_o
);

    localparam logic [7:0]          DrainLast   = 8'(DrainCycles);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TimeoutCycles - 1);

    sim_status_state_e   state_q, state_d;
    logic [7:0]          drain_q, drain_d;
    logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;

    logic        accept_pass, accept_fail, pins_changed;
    logic [15:0] pins_code;
    logic        timeout_hit, verdict;
    logic        set_pass, set_fail, set_timeout, set_finish;
    logic [15:0] code_d;

    logic        pass_q, fail_q, timeout_q, finish_q;
    logic [15:0] fail_code_q;

    sim_status_debounce #(
        .PassSig      (PassSig),
        .FailPrefix   (FailPrefix),
        .StableCycles (StableCycles)
    ) u_debounce (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .gpio_i       (gpio_i),
        .gpio_en_i    (gpio_en_i),
        .fail_code    (pins_code),
        .accept_pass  (accept_pass),
        .accept_fail  (accept_fail),
        .pins_changed (pins_changed)
    );

    assign timeout_hit = (TimeoutCycles != 0) && (state_q == StRun) &&
                         !pins_changed && (to_cnt_q == TimeoutLast);
    assign verdict     = (state_q == StRun) && (accept_pass || accept_fail || timeout_hit);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q  <= StRun;
            drain_q  <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            StRun: begin
                if (pins_changed) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + TimeoutW'(1);
                end
                if (verdict) begin
                    drain_d = 8'd1;
                    state_d = (DrainLast == 8'd1) ? StDone : StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + 8'd1;
                if (drain_q + 8'd1 == DrainLast) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StRun;
        endcase
    end

    // accept_pass and accept_fail are mutually exclusive; signatures beat the timeout.
    always_comb begin
        verdict_pulse_o = 1'b0;
        set_pass        = 1'b0;
        set_fail        = 1'b0;
        set_timeout     = 1'b0;
        set_finish      = 1'b0;
        code_d          = fail_code_q;
        case (state_q)
            StRun: begin
                verdict_pulse_o = verdict;
                set_finish      = verdict && (DrainLast == 8'd1);
                if (accept_pass) begin
                    set_pass = 1'b1;
                end else if (accept_fail) begin
                    set_fail = 1'b1;
                    code_d   = pins_code;
                end else if (timeout_hit) begin
                    set_fail    = 1'b1;
                    set_timeout = 1'b1;
                    code_d      = TimeoutFailCode;
                end
            end
            StDrain: set_finish = (drain_q + 8'd1 == DrainLast);
            default: set_finish = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            finish_q    <= 1'b0;
            fail_code_q <= '0;
        end else begin
            pass_q      <= pass_q | set_pass;
            fail_q      <= fail_q | set_fail;
            timeout_q   <= timeout_q | set_timeout;
            finish_q    <= finish_q | set_finish;
            fail_code_q <= code_d;
        end
    end

    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign finish_o    = finish_q;
    assign fail_code_o = fail_code_q;

endmodule

// File: tb/tb_sim_status_monitor.sv
// Bench for sim_status_monitor: directed scenarios plus random GPIO traffic,
// every cycle compared against a run-length/quiet-time reference model.
module tb_sim_status_monitor;

    localparam logic [31:0] PassSig       = 32'hDEADBEEF;
    localparam logic [15:0] FailPrefix    = 16'hBAD0;
    localparam int          StableCycles  = 2;
    localparam int          DrainCycles   = 7;
    localparam int          TimeoutCycles = 100;

    logic        clk_sys   = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic [31:0] gpio      = '0;
    logic [31:0] gpio_en   = '0;
    logic        finish_o, pass_o, fail_o, timeout_o, verdict_pulse_o;
    logic [15:0] fail_code_o;

    int checks = 0;
    int errors = 0;

    // reference model: registered pins this cycle / last cycle, run lengths, verdict
    logic [31:0] m_pins, m_prev;
    int          run_len, quiet, cyc, v_cyc, kind;
    bit          decided;
    logic [15:0] m_code;

    sim_status_monitor #(
        .PassSig       (PassSig),
        .FailPrefix    (FailPrefix),
        .StableCycles  (StableCycles),
        .DrainCycles   (DrainCycles),
        .TimeoutCycles (TimeoutCycles),
        .TimeoutW      (32)
    ) dut (
        .clk_sys         (clk_sys),
        .rst_sys_n       (rst_sys_n),
        .gpio_i          (gpio),
        .gpio_en_i       (gpio_en),
        .finish_o        (finish_o),
        .pass_o          (pass_o),
        .fail_o          (fail_o),
        .timeout_o       (timeout_o),
        .fail_code_o     (fail_code_o),
        .verdict_pulse_o (verdict_pulse_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst_sys_n = 1'b0;
        gpio      = '0;
        gpio_en   = '0;
        #1;
        check_val("rst_pass", pass_o, 0);
        check_val("rst_fail", fail_o, 0);
        check_val("rst_timeout", timeout_o, 0);
        check_val("rst_finish", finish_o, 0);
        check_val("rst_code", fail_code_o, 0);
        check_val("rst_pulse", verdict_pulse_o, 0);
        repeat (2) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        m_pins  = '0;
        m_prev  = '0;
        run_len = 1;
        quiet   = 1;
        cyc     = 0;
        v_cyc   = 0;
        kind    = 0;
        decided = 0;
        m_code  = '0;
    endtask

    // One cycle: check outputs against the model, then drive the next inputs.
    task automatic tick(input logic [31:0] g, input logic [31:0] e);
        bit pulse_exp;
        @(negedge clk_sys);
        cyc++;
        pulse_exp = 0;
        check_val("pass_o", pass_o, decided && kind == 0);
        check_val("fail_o", fail_o, decided && kind != 0);
        check_val("timeout_o", timeout_o, decided && kind == 2);
        check_val("fail_code_o", fail_code_o, decided ? m_code : 16'h0);
        check_val("finish_o", finish_o, decided && (cyc - v_cyc >= DrainCycles));
        if (m_pins != m_prev) begin
            run_len = 1;
            quiet   = 0;
        end else begin
            if (run_len < 1000) run_len++;
            if (quiet < 100000) quiet++;
        end
        if (!decided) begin
            if (m_pins == PassSig && run_len == StableCycles) begin
                decided = 1; kind = 0; m_code = '0;
            end else if (m_pins[31:16] == FailPrefix && run_len == StableCycles) begin
                decided = 1; kind = 1; m_code = m_pins[15:0];
            end else if (quiet == TimeoutCycles) begin
                decided = 1; kind = 2; m_code = 16'hFFFF;
            end
            if (decided) begin
                v_cyc     = cyc;
                pulse_exp = 1;
            end
        end
        check_val("verdict_pulse_o", verdict_pulse_o, pulse_exp);
        gpio    = g;
        gpio_en = e;
        m_prev  = m_pins;
        m_pins  = g & e;
    endtask

    initial begin
        int pulse_cyc, finish_cyc, last_cyc, n, hold;
        logic [31:0] g, e;

        // pass with exact timing: drive in cycle 10
        do_reset();
        pulse_cyc  = 0;
        finish_cyc = 0;
        for (int i = 1; i <= 25; i++) begin
            tick((i >= 10) ? PassSig : 32'h0, 32'hFFFFFFFF);
            if (verdict_pulse_o && pulse_cyc == 0) pulse_cyc = cyc;
            if (finish_o && finish_cyc == 0) finish_cyc = cyc;
        end
        check_val("pass_pulse_cycle", pulse_cyc, 12);
        check_val("pass_finish_cycle", finish_cyc, 19);
        check_val("pass_end_pass", pass_o, 1);
        check_val("pass_end_fail", fail_o, 0);

        // enable masking
        do_reset();
        repeat (12) tick(32'hFFFFFFFF, 32'hDEADBEEF);
        check_val("mask_pass", pass_o, 1);
        do_reset();
        repeat (30) tick(32'hDEADBEEF, 32'h0000FFFF);
        check_val("mask_none_pass", pass_o, 0);
        check_val("mask_none_fail", fail_o, 0);

        // fail code, later pass ignored
        do_reset();
        repeat (4) tick(32'hBAD00042, '1);
        repeat (15) tick(PassSig, '1);
        check_val("failc_fail", fail_o, 1);
        check_val("failc_code", fail_code_o, 16'h0042);
        check_val("failc_pass", pass_o, 0);

        // glitches
        do_reset();
        repeat (3) tick(32'h0, '1);
        tick(PassSig, '1);
        repeat (3) tick(32'h0, '1);
        tick(32'hBAD00001, '1);
        repeat (12) tick(32'hBAD00002, '1);
        check_val("glitch_pass", pass_o, 0);
        check_val("glitch_code", fail_code_o, 16'h0002);

        // timeout: toggle every 50 cycles, last change in cycle 201
        do_reset();
        last_cyc = 0;
        for (int k = 0; k <= 200; k++) begin
            tick(((k / 50) % 2) ? 32'h5 : 32'hA, '1);
            last_cyc = cyc;
        end
        pulse_cyc = 0;
        for (int i = 0; i < 300 && pulse_cyc == 0; i++) begin
            tick(32'hA, '1);
            if (verdict_pulse_o) pulse_cyc = cyc;
        end
        check_val("to_latency", pulse_cyc - last_cyc, 101);
        repeat (10) tick(32'hA, '1);
        check_val("to_timeout", timeout_o, 1);
        check_val("to_code", fail_code_o, 16'hFFFF);
        check_val("to_finish", finish_o, 1);

        // reset three cycles into drain, then a fresh pass
        do_reset();
        n = 0;
        tick(PassSig, '1);
        while (!decided && n < 20) begin
            tick(PassSig, '1);
            n++;
        end
        check_val("rd_verdict_seen", decided, 1);
        repeat (3) tick(PassSig, '1);
        check_val("rd_in_drain_finish", finish_o, 0);
        do_reset();
        repeat (12) tick(PassSig, '1);
        check_val("rd_new_pass", pass_o, 1);
        check_val("rd_new_finish", finish_o, 1);

        // random traffic
        for (int it = 0; it < 40; it++) begin
            do_reset();
            n = 0;
            while (n < 70) begin
                case ($urandom_range(0, 5))
                    0:       g = 32'h0;
                    1:       g = $urandom();
                    2, 3:    g = PassSig;
                    default: g = {FailPrefix, 16'($urandom())};
                endcase
                e    = ($urandom_range(0, 3) == 0) ? 32'($urandom()) : 32'hFFFFFFFF;
                hold = ($urandom_range(0, 15) == 0) ? 110 : $urandom_range(1, 4);
                repeat (hold) tick(g, e);
                n += hold;
            end
            repeat (10) tick(32'h0, '1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
